// File: rtl/nonce_dispatcher_pkg.sv
// Shared types and constants for the nonce dispatcher and the SHA-256 cores it feeds.
// The state enum, IV words and result width live here so the hash core can reuse them.
package nonce_dispatcher_pkg;

  localparam int RESULT_W = 32;
  localparam int ADDR_W   = 16;
  localparam int CNT_W    = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // H0..H7 packed with H0 in the most significant word
  localparam logic [8*RESULT_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [RESULT_W-1:0] sha256_iv(input int unsigned idx);
    return SHA256_IV[(7 - (idx % 8))*RESULT_W +: RESULT_W];
  endfunction

  function automatic logic [ADDR_W-1:0] result_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] tag);
    return base + tag;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last one granted.
// The remembered index only moves when something is granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;

  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    grant  = '0;
    last_d = last_q;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        last_d     = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else if (|grant) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Hands consecutive nonces to a bank of external hash cores and writes each core's H0
// result to base+nonce, launching and retiring at most one core per cycle.
module nonce_dispatcher
  import nonce_dispatcher_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             output_addr,
  output logic                          done,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [RESULT_W-1:0]           mem_write_data,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [RESULT_W*NUM_CORES-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]          core_valid,
  input  logic [RESULT_W*NUM_CORES-1:0] core_h0,
  output logic [NUM_CORES-1:0]          core_ack
);

  localparam int               IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(NUM_NONCES);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    base_q;
  logic [ADDR_W-1:0]    tag_q [NUM_CORES];
  logic [CNT_W-1:0]     next_nonce_q;
  logic [CNT_W-1:0]     written_q;
  logic [NUM_CORES-1:0] busy_q;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] grant;
  logic [NUM_CORES-1:0] launch_vec;
  logic [IDX_W-1:0]     launch_idx;
  logic [IDX_W-1:0]     retire_idx;
  logic                 launch;
  logic                 retire;
  logic                 accept;

  assign accept = (state_q == ST_IDLE) && start;
  assign retire = |grant;

  // A result counts only from a busy core past its launch cycle, so stale valids are dropped
  assign eligible = (state_q == ST_RUN) ? (core_valid & busy_q & ~core_start) : '0;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (eligible),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (written_q == TOTAL) state_d = ST_DONE;
      ST_DONE: if (!start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Descending scan leaves the lowest-index idle core selected
  always_comb begin
    launch     = 1'b0;
    launch_idx = '0;
    launch_vec = '0;
    if (state_q == ST_RUN && next_nonce_q < TOTAL) begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (!busy_q[i]) begin
          launch     = 1'b1;
          launch_idx = IDX_W'(i);
        end
      end
    end
    if (launch) launch_vec[launch_idx] = 1'b1;
  end

  always_comb begin
    retire_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) retire_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) base_q <= output_addr;
    if (launch) tag_q[launch_idx] <= next_nonce_q[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      core_start     <= '0;
      core_ack       <= '0;
      core_nonce     <= '0;
      busy_q         <= '0;
      next_nonce_q   <= '0;
      written_q      <= '0;
    end else begin
      state_q    <= state_d;
      core_start <= launch_vec;
      core_ack   <= grant;
      mem_we     <= retire;
      // A retired core frees up at this edge, so it can relaunch from the following cycle
      busy_q     <= (busy_q | launch_vec) & ~grant;
      if (retire) begin
        mem_addr       <= result_addr(base_q, tag_q[retire_idx]);
        mem_write_data <= core_h0[retire_idx*RESULT_W +: RESULT_W];
        written_q      <= written_q + 1'b1;
      end
      if (launch) begin
        core_nonce[launch_idx*RESULT_W +: RESULT_W] <= RESULT_W'(next_nonce_q);
        next_nonce_q <= next_nonce_q + 1'b1;
      end
      if (accept) begin
        next_nonce_q <= '0;
        written_q    <= '0;
        done         <= 1'b0;
      end else if (state_q == ST_RUN && state_d == ST_DONE) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Randomized bench for nonce_dispatcher: behavioural hash-core models, a write scoreboard
// keyed by nonce offset, and a second small instance with fewer nonces than cores.
module tb_nonce_dispatcher;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  output_addr = 16'h0000;
  logic         done, mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;
  logic [3:0]   core_start, core_ack;
  logic [127:0] core_nonce;
  logic [3:0]   core_valid = '0;
  logic [127:0] core_h0 = '0;

  logic         start2 = 1'b0;
  logic         done2, we2;
  logic [15:0]  addr2;
  logic [31:0]  wd2;
  logic [3:0]   cs2, ack2;
  logic [127:0] cn2;
  logic [3:0]   cv2 = '0;
  logic [127:0] h02 = '0;

  always #5 clk = ~clk;

  nonce_dispatcher #(.NUM_CORES(4), .NUM_NONCES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .output_addr(output_addr),
    .done(done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .core_start(core_start), .core_nonce(core_nonce), .core_valid(core_valid),
    .core_h0(core_h0), .core_ack(core_ack)
  );

  nonce_dispatcher #(.NUM_CORES(4), .NUM_NONCES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .output_addr(16'h0200),
    .done(done2), .mem_we(we2), .mem_addr(addr2), .mem_write_data(wd2),
    .core_start(cs2), .core_nonce(cn2), .core_valid(cv2),
    .core_h0(h02), .core_ack(ack2)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hash core models: result appears a chosen number of cycles after launch, held until acked
  int          lat_mode = 0;
  int          cnt_a [4] = '{default: 0};
  logic [31:0] nonce_a [4] = '{default: 32'h0};
  int          cnt_b [4] = '{default: 0};
  logic [31:0] nonce_b [4] = '{default: 32'h0};

  function automatic int pick_lat(input int i);
    if (lat_mode == 1) return int'($urandom_range(40, 3));
    if (lat_mode == 2) return 12 - i;
    return 10;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (core_start[i]) begin
        nonce_a[i]    <= core_nonce[i*32 +: 32];
        cnt_a[i]      <= pick_lat(i);
        core_valid[i] <= 1'b0;
      end else begin
        if (cnt_a[i] > 0) cnt_a[i] <= cnt_a[i] - 1;
        if (cnt_a[i] == 1) begin
          core_valid[i]        <= 1'b1;
          core_h0[i*32 +: 32]  <= nonce_a[i] ^ 32'hA5A5A5A5;
        end else if (core_ack[i]) begin
          core_valid[i] <= 1'b0;
        end
      end
      if (cs2[i]) begin
        nonce_b[i] <= cn2[i*32 +: 32];
        cnt_b[i]   <= 5;
        cv2[i]     <= 1'b0;
      end else begin
        if (cnt_b[i] > 0) cnt_b[i] <= cnt_b[i] - 1;
        if (cnt_b[i] == 1) begin
          cv2[i]           <= 1'b1;
          h02[i*32 +: 32]  <= nonce_b[i] ^ 32'hA5A5A5A5;
        end else if (ack2[i]) begin
          cv2[i] <= 1'b0;
        end
      end
    end
  end

  // Scoreboard: cumulative per-offset write counts and last data relative to the job base
  logic [15:0] exp_base = 16'h0100;
  wire  [15:0] mon_off  = mem_addr - exp_base;
  wire  [15:0] mon_off2 = addr2 - 16'h0200;
  int          wr_cnt [16] = '{default: 0};
  logic [31:0] wr_data [16] = '{default: 32'h0};
  int          wr_bad = 0;
  int          start_cnt = 0;
  int          cyc = 0;
  logic [3:0]  ack_q [$];
  int          ackc_q [$];
  logic        ackwe_q [$];
  int          starts2 [4] = '{default: 0};
  int          wr2_n = 0;
  int          wr2_bad = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      if (mon_off < 16'd16) begin
        wr_cnt[mon_off[3:0]]  <= wr_cnt[mon_off[3:0]] + 1;
        wr_data[mon_off[3:0]] <= mem_write_data;
      end else begin
        wr_bad <= wr_bad + 1;
      end
    end
    start_cnt <= start_cnt + $countones(core_start);
    if (|core_ack) begin
      ack_q.push_back(core_ack);
      ackc_q.push_back(cyc);
      ackwe_q.push_back(mem_we);
    end
    for (int i = 0; i < 4; i++) if (cs2[i]) starts2[i] <= starts2[i] + 1;
    if (we2) begin
      wr2_n <= wr2_n + 1;
      if (mon_off2 >= 16'd2 || wd2 != ({16'h0, mon_off2} ^ 32'hA5A5A5A5)) wr2_bad <= wr2_bad + 1;
    end
  end

  int pre_cnt [16];
  int pre_bad;
  int pre_starts;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 16; i++) pre_cnt[i] = wr_cnt[i];
    pre_bad    = wr_bad;
    pre_starts = start_cnt;
  endtask

  task automatic verify_job(input string tag);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("%s_cnt[%0d]", tag, i), 128'(wr_cnt[i] - pre_cnt[i]), 128'd1);
      check_eq($sformatf("%s_data[%0d]", tag, i), 128'(wr_data[i]),
               128'(i ^ 32'hA5A5A5A5));
    end
    check_eq({tag, "_stray"}, 128'(wr_bad - pre_bad), 128'd0);
    check_eq({tag, "_launches"}, 128'(start_cnt - pre_starts), 128'd16);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check_eq(tag, 128'(done), 128'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_done"}, 128'(done), 128'd0);
    check_eq({tag, "_we"}, 128'(mem_we), 128'd0);
    check_eq({tag, "_addr"}, 128'(mem_addr), 128'd0);
    check_eq({tag, "_wdata"}, 128'(mem_write_data), 128'd0);
    check_eq({tag, "_cstart"}, 128'(core_start), 128'd0);
    check_eq({tag, "_ack"}, 128'(core_ack), 128'd0);
    check_eq({tag, "_nonce"}, 128'(core_nonce), 128'd0);
  endtask

  logic [3:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int k0;
    repeat (3) tick();
    check_reset_vals("por");
    reset_n = 1'b1;
    tick();

    // Job 1: fixed latency, start held high through RUN and DONE
    lat_mode    = 0;
    exp_base    = 16'h0100;
    output_addr = 16'h0100;
    snap();
    start = 1'b1;
    tick();
    output_addr = 16'h1234;
    wait_done("job1_done");
    repeat (12) tick();
    check_eq("held_start_done", 128'(done), 128'd1);
    check_eq("held_start_we", 128'(mem_we), 128'd0);
    verify_job("job1");
    start = 1'b0;
    repeat (3) tick();
    check_eq("idle_done_held", 128'(done), 128'd1);

    // Job 2: random core latencies, out-of-order completion
    lat_mode    = 1;
    output_addr = 16'h0100;
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("accept_clears_done", 128'(done), 128'd0);
    wait_done("job2_done");
    tick();
    verify_job("job2");

    // Job 3: abandoned by reset partway through
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrun_rst");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Job 4: aligned completions exercise round-robin retirement; base wraps past 0xFFFF
    lat_mode    = 2;
    exp_base    = 16'hFFFE;
    output_addr = 16'hFFFE;
    k0 = ack_q.size();
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("job4_done");
    tick();
    verify_job("job4");
    check_eq("rr_ack_count_ok", 128'(ack_q.size() >= k0 + 4), 128'd1);
    if (ack_q.size() >= k0 + 4) begin
      for (int j = 0; j < 4; j++) begin
        check_eq($sformatf("rr_grant[%0d]", j), 128'(ack_q[k0+j]), 128'(rr_exp[j]));
        check_eq($sformatf("rr_cycle[%0d]", j), 128'(ackc_q[k0+j] - ackc_q[k0]), 128'(j));
        check_eq($sformatf("rr_we[%0d]", j), 128'(ackwe_q[k0+j]), 128'd1);
      end
    end

    // Fewer nonces than cores on the second instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 0; n < 200 && done2 !== 1'b1; n++) tick();
    check_eq("small_done", 128'(done2), 128'd1);
    repeat (5) tick();
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("small_starts[%0d]", i), 128'(starts2[i]), (i < 2) ? 128'd1 : 128'd0);
    check_eq("small_writes", 128'(wr2_n), 128'd2);
    check_eq("small_bad", 128'(wr2_bad), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
